// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_2r1w register file.
//   - state_e               : clear-sequencer states (IDLE, CLEAR)
//   - REGFILE_WIDTH_DEF     : default entry width in bits
//   - REGFILE_DEPTH_DEF     : default number of entries
//   - addr_in_range()       : true when an address selects a real entry
// Optional feature macro used by the design: REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int REGFILE_WIDTH_DEF = 32;
  localparam int REGFILE_DEPTH_DEF = 32;

  // The address is zero-extended to 32 bits by the caller, so this works
  // for any ADDR_W, including non-power-of-two depths.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_2r1w.
//   clk, reset    : clock, synchronous active-high reset
//   rEnable_i     : read request this cycle
//   rAddr_i       : read address (may exceed DEPTH-1; such reads return 0)
//   mem_i         : storage array contents (pre-edge values)
//   rData_o       : registered read data, holds while no read is issued
//   rValid_o      : one-cycle pulse when rData_o was updated
// With REGFILE_BYPASS_EN defined, extra inputs describe the write accepted
// and the entry being cleared on the same edge, so the port can forward
// the post-edge value instead of the stale array contents.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REGFILE_WIDTH_DEF,
  parameter int DEPTH  = REGFILE_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rEnable_i,
  input  logic [ADDR_W-1:0] rAddr_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic              wrAccept_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]  wrData_i,
  input  logic              clrActive_i,
  input  logic [ADDR_W-1:0] clrAddr_i,
`endif
  output logic [WIDTH-1:0]  rData_o,
  output logic              rValid_o
);

  logic             in_range;
  logic [WIDTH-1:0] rData_d;
  logic [WIDTH-1:0] rData_q;
  logic             rValid_q;

  always_comb begin
    in_range = addr_in_range(32'(rAddr_i), 32'(DEPTH));
    rData_d  = '0;
    if (in_range) begin
      rData_d = mem_i[rAddr_i];
`ifdef REGFILE_BYPASS_EN
      // A clear and an accepted write never coincide (writes are blocked
      // while clearing), so the priority order here is immaterial.
      if (clrActive_i && (clrAddr_i == rAddr_i)) begin
        rData_d = '0;
      end else if (wrAccept_i && (wrAddr_i == rAddr_i)) begin
        rData_d = wrData_i;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rData_q  <= '0;
      rValid_q <= 1'b0;
    end else begin
      rValid_q <= rEnable_i;
      if (rEnable_i) begin
        rData_q <= rData_d;
      end
    end
  end

  assign rData_o  = rData_q;
  assign rValid_o = rValid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file, one write port, two
// independent registered read ports, and a clear sequencer that zeroes
// one entry per cycle.
//   clk, reset           : clock, synchronous active-high reset (zeroes all)
//   wEnable/wAddr/wData  : write request; dropped while clearing or if
//                          wAddr >= DEPTH
//   wReady               : high when a write would be accepted
//   rEnableX/rAddrX      : read request for port X (A or B)
//   rDataX/rValidX       : registered read data / one-cycle valid pulse
//   clrReq               : start a full-array clear (ignored while clearing)
//   clrBusy              : clear in progress, high for exactly DEPTH cycles
// Optional macro REGFILE_BYPASS_EN: reads colliding with a same-edge write
// return the new data, and reads of the entry being cleared return 0.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH_DEF,
  parameter int DEPTH    = REGFILE_DEPTH_DEF,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wEnable,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [WIDTH-1:0]  wData,
  output logic              wReady,
  input  logic              rEnableA,
  input  logic [ADDR_W-1:0] rAddrA,
  output logic [WIDTH-1:0]  rDataA,
  output logic              rValidA,
  input  logic              rEnableB,
  input  logic [ADDR_W-1:0] rAddrB,
  output logic [WIDTH-1:0]  rDataB,
  output logic              rValidB,
  input  logic              clrReq,
  output logic              clrBusy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_accept;

  // Clear sequencer: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clrReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clrBusy   = (state_q == CLEAR);
  assign wReady    = !clrBusy;
  assign wr_accept = wEnable && wReady && addr_in_range(32'(wAddr), 32'(DEPTH));

  // Storage: reset zeroes everything, otherwise either the sequencer
  // clears one entry or an accepted write lands (never both).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clrBusy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_accept) begin
      mem_q[wAddr] <= wData;
    end
  end

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .clk         (clk),
    .reset       (reset),
    .rEnable_i   (rEnableA),
    .rAddr_i     (rAddrA),
    .mem_i       (mem_q),
`ifdef REGFILE_BYPASS_EN
    .wrAccept_i  (wr_accept),
    .wrAddr_i    (wAddr),
    .wrData_i    (wData),
    .clrActive_i (clrBusy),
    .clrAddr_i   (cnt_q),
`endif
    .rData_o     (rDataA),
    .rValid_o    (rValidA)
  );

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .clk         (clk),
    .reset       (reset),
    .rEnable_i   (rEnableB),
    .rAddr_i     (rAddrB),
    .mem_i       (mem_q),
`ifdef REGFILE_BYPASS_EN
    .wrAccept_i  (wr_accept),
    .wrAddr_i    (wAddr),
    .wrData_i    (wData),
    .clrActive_i (clrBusy),
    .clrAddr_i   (cnt_q),
`endif
    .rData_o     (rDataB),
    .rValid_o    (rValidB)
  );

endmodule
